// File: rtl/cpu_pkg.sv
// Shared core definitions: next-PC select encodings, word sizes and the fetch-queue entry.
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'd0,
    PC_SRC_JUMP   = 2'd1,
    PC_SRC_BRANCH = 2'd2,
    PC_SRC_RSVD   = 2'd3
  } pc_src_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic logic is_redirect(input logic [1:0] src);
    return (src == PC_SRC_JUMP) || (src == PC_SRC_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus: redirect inputs, imem request/response channel and the decode-side head.
interface fetch_queue_stage_if;
  import cpu_pkg::*;

  logic [1:0]      PC_Src;
  logic [XLEN-1:0] jumpAddress;
  logic [XLEN-1:0] branchAddress;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] Instruction;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PC_Next;

  modport master (
    input  PC_Src, jumpAddress, branchAddress,
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dec_valid, Instruction, PC, PC_Next,
    input  dec_ready
  );

  modport slave (
    output PC_Src, jumpAddress, branchAddress,
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dec_valid, Instruction, PC, PC_Next,
    output dec_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, occupancy count and a synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests, queues {pc, instr} for decode.
// Optional macro FETCH_PERF_EN adds perf_flush_cnt / perf_stall_cnt outputs.
module fetch_queue_stage
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fetch_queue_stage_if.master fq
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OUT_W = $clog2(MAX_OUT+1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] drop_q, drop_d;
  fq_entry_t        last_q;
  logic [XLEN-1:0]  last_next_q;

  fq_entry_t        head;
  logic [2*XLEN-1:0] q_dout;
  logic [CNT_W-1:0] q_count;
  logic             q_full, q_empty;
  logic [XLEN-1:0]  tag_pc;
  logic [OUT_W-1:0] tag_count;
  logic             tag_full, tag_empty;

  logic redirect, req_fire, rsp_fire, rsp_keep, pop;

  assign redirect = is_redirect(fq.PC_Src);

  // Credit rule: every in-flight request already owns a queue slot.
  assign fq.imem_req_valid = !rst && !redirect
                             && (32'(out_q) < 32'(MAX_OUT))
                             && ((32'(q_count) + 32'(out_q)) < 32'(DEPTH));
  assign fq.imem_addr = pc_q;

  assign req_fire = fq.imem_req_valid && fq.imem_req_ready;
  assign rsp_fire = fq.imem_rsp_valid && (out_q != '0);
  assign rsp_keep = rsp_fire && (drop_q == '0) && !redirect;
  assign pop      = fq.dec_valid && fq.dec_ready && !redirect;

  assign head           = q_dout;
  assign fq.dec_valid   = !q_empty;
  assign fq.Instruction = q_empty ? last_q.instr : head.instr;
  assign fq.PC          = q_empty ? last_q.pc    : head.pc;
  assign fq.PC_Next     = q_empty ? last_next_q  : head.pc + 32'(INSTR_BYTES);

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + OUT_W'(req_fire) - OUT_W'(rsp_fire);
    drop_d = drop_q;
    if (fq.PC_Src == PC_SRC_BRANCH)    pc_d = fq.branchAddress;
    else if (fq.PC_Src == PC_SRC_JUMP) pc_d = fq.jumpAddress;
    else if (req_fire)                 pc_d = pc_q + 32'(INSTR_BYTES);
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect)                          drop_d = out_q - OUT_W'(rsp_fire);
    else if (rsp_fire && drop_q != '0)     drop_d = drop_q - OUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      out_q       <= '0;
      drop_q      <= '0;
      last_q      <= '0;
      last_next_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      if (!q_empty) begin
        last_q      <= head;
        last_next_q <= head.pc + 32'(INSTR_BYTES);
      end
    end
  end

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect),
    .push_i  (rsp_keep),
    .din_i   ({tag_pc, fq.imem_rsp_data}),
    .pop_i   (pop),
    .dout_o  (q_dout),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (1'b0),
    .push_i  (req_fire),
    .din_i   (pc_q),
    .pop_i   (rsp_fire),
    .dout_o  (tag_pc),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  a_q_no_overflow:   assert property (@(posedge clk) disable iff (rst) !(rsp_keep && q_full));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst) !(req_fire && tag_full));
  a_tag_has_req:     assert property (@(posedge clk) disable iff (rst) !(rsp_fire && tag_empty));
  a_tag_tracks_out:  assert property (@(posedge clk) disable iff (rst) tag_count == out_q);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_flush_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (redirect) perf_flush_q <= perf_flush_q + 32'd1;
      if (fq.dec_ready && !fq.dec_valid) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: acts as imem and decode, checks every cycle against a queue-based model.
module tb_fetch_queue_stage;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ALT_RESET_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          stale;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_stage_if fq();
  fetch_queue_stage_if fq2();

`ifdef FETCH_PERF_EN
  logic [31:0] pf_a, ps_a, pf_b, ps_b;
`endif

  fetch_queue_stage #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) u_dut (
    .clk(clk), .rst(rst), .fq(fq)
`ifdef FETCH_PERF_EN
    , .perf_flush_cnt(pf_a), .perf_stall_cnt(ps_a)
`endif
  );

  fetch_queue_stage #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(ALT_RESET_PC)) u_dut_alt (
    .clk(clk), .rst(rst), .fq(fq2)
`ifdef FETCH_PERF_EN
    , .perf_flush_cnt(pf_b), .perf_stall_cnt(ps_b)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  req_t        infl[$];
  fq_entry_t   mq[$];
  logic [31:0] obs_pops[$];
  logic [31:0] m_pc;
  logic [31:0] last_pc, last_instr, last_next;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  int          obs_fires = 0;
  bit          inject_junk = 0;
  int          alt_phase = -1;
  logic [31:0] alt_addr_exp [4];
  logic        alt_rv_exp [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_at(input int k);
    return (k < obs_pops.size()) ? obs_pops[k] : 32'hxxxx_xxxx;
  endfunction

  // One clock cycle: drive imem response, check at negedge, then advance the model.
  task automatic step();
    logic redir, exp_req, fire, popv;
    req_t r;
    fq.imem_rsp_valid = 1'b0;
    fq.imem_rsp_data  = '0;
    if (infl.size() > 0 && infl[0].due <= cyc) begin
      fq.imem_rsp_valid = 1'b1;
      fq.imem_rsp_data  = infl[0].data;
    end else if (inject_junk) begin
      fq.imem_rsp_valid = 1'b1;
      fq.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    inject_junk = 0;
    @(negedge clk);
    redir   = !rst && (fq.PC_Src == 2'd1 || fq.PC_Src == 2'd2);
    exp_req = !rst && !redir && (infl.size() < MAX_OUT) && (mq.size() + infl.size() < DEPTH);
    check("imem_req_valid", fq.imem_req_valid, exp_req);
    check("imem_addr", fq.imem_addr, m_pc);
    check("dec_valid", fq.dec_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("head_pc", fq.PC, mq[0].pc);
      check("head_instr", fq.Instruction, mq[0].instr);
      check("head_pc_next", fq.PC_Next, mq[0].pc + 32'd4);
    end else begin
      check("hold_pc", fq.PC, last_pc);
      check("hold_instr", fq.Instruction, last_instr);
      check("hold_pc_next", fq.PC_Next, last_next);
    end
    if (alt_phase >= 0 && alt_phase < 4) begin
      check("alt_imem_addr", fq2.imem_addr, alt_addr_exp[alt_phase]);
      check("alt_req_valid", fq2.imem_req_valid, alt_rv_exp[alt_phase]);
      alt_phase++;
    end
    if (fq.dec_valid && fq.dec_ready && !redir) obs_pops.push_back(fq.PC);
    if (fq.imem_req_valid && fq.imem_req_ready) obs_fires++;

    if (rst) begin
      m_pc = RESET_PC;
      mq.delete();
      infl.delete();
      last_pc = '0; last_instr = '0; last_next = '0;
    end else begin
      fire = exp_req && fq.imem_req_ready;
      popv = (mq.size() > 0) && fq.dec_ready && !redir;
      if (mq.size() > 0) begin
        last_pc = mq[0].pc; last_instr = mq[0].instr; last_next = mq[0].pc + 32'd4;
      end
      if (popv) void'(mq.pop_front());
      if (fq.imem_rsp_valid && infl.size() > 0) begin
        r = infl.pop_front();
        if (!r.stale && !redir) mq.push_back('{pc: r.pc, instr: r.data});
      end
      if (redir) begin
        mq.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
        m_pc = (fq.PC_Src == 2'd2) ? fq.branchAddress : fq.jumpAddress;
      end else if (fire) begin
        r.pc    = m_pc;
        r.data  = $urandom();
        r.due   = cyc + $urandom_range(lat_max, lat_min);
        if (infl.size() > 0 && r.due <= infl[$].due) r.due = infl[$].due + 1;
        r.stale = 1'b0;
        infl.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs_pops.delete();
    obs_fires = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    alt_addr_exp = '{ALT_RESET_PC, ALT_RESET_PC, 32'hFFFF_FFFC, 32'h0000_0000};
    alt_rv_exp   = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    fq.PC_Src = 2'd0; fq.jumpAddress = '0; fq.branchAddress = '0;
    fq.imem_req_ready = 1'b1; fq.dec_ready = 1'b1;
    fq.imem_rsp_valid = 1'b0; fq.imem_rsp_data = '0;
    fq2.PC_Src = 2'd0; fq2.jumpAddress = '0; fq2.branchAddress = '0;
    fq2.imem_req_ready = 1'b1; fq2.dec_ready = 1'b0;
    fq2.imem_rsp_valid = 1'b0; fq2.imem_rsp_data = '0;
    m_pc = RESET_PC; last_pc = '0; last_instr = '0; last_next = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then free-run at latency 1 (alt instance checks PC wrap from its reset value).
    alt_phase = 0;
    do_reset();
    repeat (20) step();
    for (int k = 0; k < 6; k++) check("seq_pc", pop_at(k), 32'(k * 4));

    // Decode stall: only DEPTH requests may be accepted.
    do_reset();
    fq.dec_ready = 1'b0;
    repeat (10) step();
    check("stall_fires", 32'(obs_fires), 32'(DEPTH));
    check("stall_head_pc", fq.PC, 32'h0);

    // Jump with two requests in flight at latency 2.
    fq.dec_ready = 1'b1;
    do_reset();
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 10 && infl.size() < 2; i++) step();
    obs_pops.delete();
    fq.PC_Src = 2'd1; fq.jumpAddress = 32'h100;
    step();
    fq.PC_Src = 2'd0;
    repeat (15) step();
    check("jump_pc0", pop_at(0), 32'h100);
    check("jump_pc1", pop_at(1), 32'h104);

    // Branch in the same cycle as a pop.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10 && mq.size() == 0; i++) step();
    fq.PC_Src = 2'd2; fq.branchAddress = 32'h40; fq.jumpAddress = 32'h200;
    step();
    fq.PC_Src = 2'd0;
    obs_pops.delete();
    step();
    check("branch_dec_valid", fq.dec_valid, 1'b0);
    repeat (10) step();
    check("branch_pc0", pop_at(0), 32'h40);

    // PC wrap through the top of the address space.
    fq.PC_Src = 2'd1; fq.jumpAddress = 32'hFFFF_FFF8;
    step();
    fq.PC_Src = 2'd0;
    obs_pops.delete();
    repeat (12) step();
    check("wrap_pc0", pop_at(0), 32'hFFFF_FFF8);
    check("wrap_pc1", pop_at(1), 32'hFFFF_FFFC);
    check("wrap_pc2", pop_at(2), 32'h0000_0000);

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      fq.imem_req_ready = ($urandom_range(0, 99) < 70);
      fq.dec_ready      = ($urandom_range(0, 99) < 60);
      fq.jumpAddress    = {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 255) * 4);
      fq.branchAddress  = $urandom() & 32'hFFFF_FFFC;
      case ($urandom_range(0, 99))
        0, 1, 2: fq.PC_Src = 2'd1;
        3, 4, 5: fq.PC_Src = 2'd2;
        6, 7:    fq.PC_Src = 2'd3;
        default: fq.PC_Src = 2'd0;
      endcase
      step();
    end
    fq.PC_Src = 2'd0;
    fq.imem_req_ready = 1'b1;

    // Reset with requests in flight and entries queued; stale responses must never surface.
    lat_min = 3; lat_max = 3;
    fq.dec_ready = 1'b0;
    for (int i = 0; i < 20 && !(infl.size() > 0 && mq.size() > 0); i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    obs_pops.delete();
    inject_junk = 1;
    fq.dec_ready = 1'b1;
    check("rst_dec_valid", fq.dec_valid, 1'b0);
    check("rst_pc", fq.PC, 32'h0);
    check("rst_instr", fq.Instruction, 32'h0);
    check("rst_pc_next", fq.PC_Next, 32'h0);
    repeat (12) step();
    check("post_rst_pc0", pop_at(0), RESET_PC);
    check("post_rst_pc1", pop_at(1), RESET_PC + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
